// File: rtl/decoder_sequencer.sv
// Decode sequencer: arbitrates the ID-stage decoder between fetch and debug
// injection and buffers decoded entries in a DEPTH-entry issue queue.
// Optional performance counters are enabled by defining DECODER_SEQUENCER_PERF_EN.

package decoder_sequencer_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        valid;
  } scoreboard_entry_t;
endpackage

module decoder_sequencer
  import decoder_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              debug_mode_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [63:0]       fetch_pc_i,
  input  logic [31:0]       fetch_instr_i,
  input  logic              fetch_is_compressed_i,
  input  logic              dbg_valid_i,
  output logic              dbg_ready_o,
  input  logic [63:0]       dbg_pc_i,
  input  logic [31:0]       dbg_instr_i,
  output logic [63:0]       dec_pc_o,
  output logic [31:0]       dec_instr_o,
  output logic              dec_is_compressed_o,
  input  scoreboard_entry_t dec_entry_i,
  input  logic              dec_is_ctrl_flow_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output scoreboard_entry_t issue_entry_o,
  output logic              issue_is_ctrl_flow_o,
  output logic              issue_src_dbg_o,
  output logic [31:0]       perf_issued_o,
  output logic [31:0]       perf_stall_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DEBUG = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              full_s;
  logic              fetch_ready_s;
  logic              dbg_ready_s;
  logic              issue_valid_s;
  logic              push_s;
  logic              pop_s;

  scoreboard_entry_t entry_mem_r [DEPTH];
  logic              ctrl_mem_r  [DEPTH];
  logic              src_mem_r   [DEPTH];

  assign full_s        = (count_r == CNT_FULL);
  assign issue_valid_s = (count_r != {(AW+1){1'b0}});

  // Readies: owner-only, no pass-through when full, closed during flush and reset.
  always_comb begin
    fetch_ready_s = 1'b0;
    dbg_ready_s   = 1'b0;
    if (rst_ni && !flush_i && !full_s) begin
      if (state_r == ST_RUN) begin
        fetch_ready_s = 1'b1;
      end else if (state_r == ST_DEBUG) begin
        dbg_ready_s = 1'b1;
      end else begin
        fetch_ready_s = 1'b0;
        dbg_ready_s   = 1'b0;
      end
    end else begin
      fetch_ready_s = 1'b0;
      dbg_ready_s   = 1'b0;
    end
  end

  assign push_s = (fetch_valid_i & fetch_ready_s) | (dbg_valid_i & dbg_ready_s);
  assign pop_s  = issue_valid_s & issue_ready_i & ~flush_i;

  // Decoder input mux, selected by ownership state only.
  always_comb begin
    dec_pc_o            = fetch_pc_i;
    dec_instr_o         = fetch_instr_i;
    dec_is_compressed_o = fetch_is_compressed_i;
    if (state_r == ST_DEBUG) begin
      dec_pc_o            = dbg_pc_i;
      dec_instr_o         = dbg_instr_i;
      dec_is_compressed_o = 1'b0;
    end else begin
      dec_pc_o            = fetch_pc_i;
      dec_instr_o         = fetch_instr_i;
      dec_is_compressed_o = fetch_is_compressed_i;
    end
  end

  // Ownership FSM: switching always passes through DRAIN until the queue empties.
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = debug_mode_i ? ST_DEBUG : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:   state_next_s = debug_mode_i ? ST_DRAIN : ST_RUN;
        ST_DEBUG: state_next_s = debug_mode_i ? ST_DEBUG : ST_DRAIN;
        ST_DRAIN: begin
          if (count_r == {(AW+1){1'b0}}) begin
            state_next_s = debug_mode_i ? ST_DEBUG : ST_RUN;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
        default:  state_next_s = ST_RUN;
      endcase
    end
  end

  // State, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_RUN;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      state_r  <= state_next_s;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      state_r <= state_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents are only observed behind a nonzero count.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      entry_mem_r[wr_ptr_r] <= dec_entry_i;
      ctrl_mem_r[wr_ptr_r]  <= dec_is_ctrl_flow_i;
      src_mem_r[wr_ptr_r]   <= dbg_ready_s;
    end
  end

  assign fetch_ready_o        = fetch_ready_s;
  assign dbg_ready_o          = dbg_ready_s;
  assign issue_valid_o        = issue_valid_s;
  assign issue_entry_o        = entry_mem_r[rd_ptr_r];
  assign issue_is_ctrl_flow_o = ctrl_mem_r[rd_ptr_r];
  assign issue_src_dbg_o      = issue_valid_s & src_mem_r[rd_ptr_r];

`ifdef DECODER_SEQUENCER_PERF_EN
  logic [31:0] perf_issued_r;
  logic [31:0] perf_stall_r;

  // Free-running counters, cleared by reset only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      if (issue_valid_s && issue_ready_i) begin
        perf_issued_r <= perf_issued_r + 32'd1;
      end
      if (fetch_valid_i && !fetch_ready_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_issued_o = perf_issued_r;
  assign perf_stall_o  = perf_stall_r;
`else
  assign perf_issued_o = 32'd0;
  assign perf_stall_o  = 32'd0;
`endif

endmodule

// File: tb/tb_decoder_sequencer.sv
// Randomized bench for decoder_sequencer against a queue-based ownership model.
// Perf expectations follow DECODER_SEQUENCER_PERF_EN.

module tb_decoder_sequencer;
  import decoder_sequencer_pkg::*;

  localparam int DEPTH      = 4;
  localparam int OWN_FETCH  = 0;
  localparam int OWN_SWITCH = 1;
  localparam int OWN_DEBUG  = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              debug_mode_i = 1'b0;
  logic              fetch_valid_i = 1'b0;
  logic              fetch_ready_o;
  logic [63:0]       fetch_pc_i = 64'h0;
  logic [31:0]       fetch_instr_i = 32'h0;
  logic              fetch_is_compressed_i = 1'b0;
  logic              dbg_valid_i = 1'b0;
  logic              dbg_ready_o;
  logic [63:0]       dbg_pc_i = 64'h0;
  logic [31:0]       dbg_instr_i = 32'h0;
  logic [63:0]       dec_pc_o;
  logic [31:0]       dec_instr_o;
  logic              dec_is_compressed_o;
  scoreboard_entry_t dec_entry_i = '0;
  logic              dec_is_ctrl_flow_i = 1'b0;
  logic              issue_valid_o;
  logic              issue_ready_i = 1'b0;
  scoreboard_entry_t issue_entry_o;
  logic              issue_is_ctrl_flow_o;
  logic              issue_src_dbg_o;
  logic [31:0]       perf_issued_o;
  logic [31:0]       perf_stall_o;

  decoder_sequencer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
    .fetch_is_compressed_i(fetch_is_compressed_i),
    .dbg_valid_i(dbg_valid_i), .dbg_ready_o(dbg_ready_o),
    .dbg_pc_i(dbg_pc_i), .dbg_instr_i(dbg_instr_i),
    .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o), .dec_is_compressed_o(dec_is_compressed_o),
    .dec_entry_i(dec_entry_i), .dec_is_ctrl_flow_i(dec_is_ctrl_flow_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_entry_o(issue_entry_o), .issue_is_ctrl_flow_o(issue_is_ctrl_flow_o),
    .issue_src_dbg_o(issue_src_dbg_o),
    .perf_issued_o(perf_issued_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    scoreboard_entry_t entry;
    logic              ctrl;
    logic              src;
  } item_t;

  item_t       model_q[$];
  int          owner;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_issued;
  logic [31:0] exp_stall;
  logic [63:0] next_fetch_pc;
  logic        hold_fetch;
  logic        hold_dbg;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_perf();
`ifdef DECODER_SEQUENCER_PERF_EN
    check("perf_issued", 128'(perf_issued_o), 128'(exp_issued));
    check("perf_stall", 128'(perf_stall_o), 128'(exp_stall));
`else
    check("perf_issued_tied", 128'(perf_issued_o), 128'(0));
    check("perf_stall_tied", 128'(perf_stall_o), 128'(0));
`endif
  endtask

  task automatic model_reset();
    model_q.delete();
    owner      = OWN_FETCH;
    exp_issued = 32'd0;
    exp_stall  = 32'd0;
    hold_fetch = 1'b0;
    hold_dbg   = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance model at posedge.
  task automatic step(input int p_fv, input int p_ir, input int p_fl, input int p_dv, input logic dm);
    logic [95:0] rnd;
    logic        exp_fr, exp_dr, exp_iv, fire_f, fire_d, pop;
    int          size0;
    item_t       head, it;
    @(negedge clk_i);
    debug_mode_i  = dm;
    flush_i       = ($urandom_range(99) < p_fl);
    issue_ready_i = ($urandom_range(99) < p_ir);
    if (!hold_fetch) begin
      fetch_valid_i         = ($urandom_range(99) < p_fv);
      fetch_pc_i            = next_fetch_pc;
      fetch_instr_i         = $urandom;
      fetch_is_compressed_i = 1'($urandom_range(1));
    end
    if (!hold_dbg) begin
      dbg_valid_i = ($urandom_range(99) < p_dv);
      dbg_pc_i    = {32'h0, $urandom};
      dbg_instr_i = ($urandom_range(1) == 1) ? 32'h0010_0073 : $urandom;
    end
    rnd = {$urandom, $urandom, $urandom};
    dec_entry_i        = scoreboard_entry_t'(rnd[$bits(scoreboard_entry_t)-1:0]);
    dec_is_ctrl_flow_i = 1'($urandom_range(1));
    #1;
    exp_fr = (owner == OWN_FETCH) && (model_q.size() < DEPTH) && !flush_i;
    exp_dr = (owner == OWN_DEBUG) && (model_q.size() < DEPTH) && !flush_i;
    exp_iv = (model_q.size() != 0);
    check("fetch_ready", 128'(fetch_ready_o), 128'(exp_fr));
    check("dbg_ready", 128'(dbg_ready_o), 128'(exp_dr));
    check("issue_valid", 128'(issue_valid_o), 128'(exp_iv));
    if (exp_iv) begin
      head = model_q[0];
      check("issue_entry", 128'(issue_entry_o), 128'(head.entry));
      check("issue_ctrl", 128'(issue_is_ctrl_flow_o), 128'(head.ctrl));
      check("issue_src_dbg", 128'(issue_src_dbg_o), 128'(head.src));
    end
    if (owner == OWN_DEBUG) begin
      check("dec_pc_dbg", 128'(dec_pc_o), 128'(dbg_pc_i));
      check("dec_instr_dbg", 128'(dec_instr_o), 128'(dbg_instr_i));
      check("dec_c_dbg", 128'(dec_is_compressed_o), 128'(0));
    end else begin
      check("dec_pc_fetch", 128'(dec_pc_o), 128'(fetch_pc_i));
      check("dec_instr_fetch", 128'(dec_instr_o), 128'(fetch_instr_i));
      check("dec_c_fetch", 128'(dec_is_compressed_o), 128'(fetch_is_compressed_i));
    end
    check_perf();
    fire_f = fetch_valid_i && exp_fr;
    fire_d = dbg_valid_i && exp_dr;
    pop    = exp_iv && issue_ready_i;
    @(posedge clk_i);
    if (pop) exp_issued = exp_issued + 32'd1;
    if (fetch_valid_i && !exp_fr) exp_stall = exp_stall + 32'd1;
    if (flush_i) begin
      model_q.delete();
      owner = dm ? OWN_DEBUG : OWN_FETCH;
    end else begin
      size0 = model_q.size();
      if (pop) void'(model_q.pop_front());
      if (fire_f || fire_d) begin
        it.entry = dec_entry_i;
        it.ctrl  = dec_is_ctrl_flow_i;
        it.src   = fire_d;
        model_q.push_back(it);
      end
      if (owner == OWN_FETCH && dm) owner = OWN_SWITCH;
      else if (owner == OWN_DEBUG && !dm) owner = OWN_SWITCH;
      else if (owner == OWN_SWITCH && size0 == 0) owner = dm ? OWN_DEBUG : OWN_FETCH;
    end
    hold_fetch = fetch_valid_i && !fire_f;
    hold_dbg   = dbg_valid_i && !fire_d;
    if (fire_f) next_fetch_pc = next_fetch_pc + 64'd4;
  endtask

  // Reset pulse away from clock edges, checking the asynchronous clear.
  task automatic async_reset_mid();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_issue_valid", 128'(issue_valid_o), 128'(0));
    check("rst_fetch_ready", 128'(fetch_ready_o), 128'(0));
    check("rst_dbg_ready", 128'(dbg_ready_o), 128'(0));
    check("rst_src_dbg", 128'(issue_src_dbg_o), 128'(0));
    check("rst_perf_issued", 128'(perf_issued_o), 128'(0));
    check("rst_perf_stall", 128'(perf_stall_o), 128'(0));
    model_reset();
    flush_i       = 1'b0;
    debug_mode_i  = 1'b0;
    fetch_valid_i = 1'b0;
    dbg_valid_i   = 1'b0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    #1;
    check("release_fetch_ready", 128'(fetch_ready_o), 128'(1));
    check("release_issue_valid", 128'(issue_valid_o), 128'(0));
  endtask

  initial begin
    int p_fv, p_ir, p_fl, p_dv;
    logic dm;
    model_reset();
    next_fetch_pc = 64'h8000_0000;
    #1;
    check("reset_issue_valid", 128'(issue_valid_o), 128'(0));
    check("reset_fetch_ready", 128'(fetch_ready_o), 128'(0));
    check("reset_dbg_ready", 128'(dbg_ready_o), 128'(0));
    check("reset_src_dbg", 128'(issue_src_dbg_o), 128'(0));
    check("reset_perf_issued", 128'(perf_issued_o), 128'(0));
    check("reset_perf_stall", 128'(perf_stall_o), 128'(0));
    #6;
    rst_ni = 1'b1;
    #1;
    check("first_fetch_ready", 128'(fetch_ready_o), 128'(1));

    // Straight-line fetch stream with the issue side always ready.
    for (int i = 0; i < 6; i++) step(100, 100, 0, 0, 1'b0);
    // Fill past full with issue stalled, then release.
    for (int i = 0; i < 8; i++) step(100, 0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step(100, 100, 0, 0, 1'b0);
    // Three queued, then switch into debug and inject.
    for (int i = 0; i < 3; i++) step(100, 0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 100, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 100, 0, 100, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 100, 0, 0, 1'b0);
    // Full queue with wrapped pointers, flush alongside push and pop.
    for (int i = 0; i < 6; i++) step(100, 0, 0, 0, 1'b0);
    step(100, 100, 100, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    step(100, 100, 0, 0, 1'b0);
    step(0, 100, 0, 0, 1'b0);
    // Hold at DEPTH-1 entries while pushing and popping every cycle.
    for (int i = 0; i < 3; i++) step(100, 0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) step(100, 100, 0, 0, 1'b0);
    // Randomized blocks.
    for (int blk = 0; blk < 15; blk++) begin
      p_fv = $urandom_range(100);
      p_ir = $urandom_range(100);
      p_fl = $urandom_range(5);
      p_dv = $urandom_range(100);
      dm   = 1'($urandom_range(1));
      for (int i = 0; i < 100; i++) step(p_fv, p_ir, p_fl, p_dv, dm);
    end
    // Asynchronous reset with two entries queued.
    for (int i = 0; i < 2; i++) step(100, 0, 0, 0, 1'b0);
    async_reset_mid();
    for (int blk = 0; blk < 4; blk++) begin
      p_fv = $urandom_range(100);
      p_ir = $urandom_range(100);
      p_fl = $urandom_range(3);
      p_dv = $urandom_range(100);
      dm   = 1'($urandom_range(1));
      for (int i = 0; i < 80; i++) step(p_fv, p_ir, p_fl, p_dv, dm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
